// File: rtl/mem_arb_pkg.sv
// Shared constants, the requester-id type and a one-hot helper for the
// memory round-robin arbiter.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_HEIGHT  = 128;

    localparam int AW = $clog2(DEF_HEIGHT);

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

    function automatic logic [DEF_NUM_REQ-1:0] onehot(input req_id_t id);
        logic [DEF_NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr_reg for the first active request.
// The pointer moves past the winner whenever advance is high.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_any
);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] pick;
    logic          found;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Grants are suppressed during reset so no memory enable can fire.
    assign gnt_any = found & ~rst;
    assign gnt_id  = pick;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = gnt_any && (pick == IW'(gi));
        end
    endgenerate

    // Explicit wrap so a non-power-of-2 N never lands on an unused index.
    assign ptr_next = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one pseudo-2-port memory between NUM_REQ requesters with independent
// round-robin arbitration of the read and write ports; read data returns registered.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    localparam int ADDR_W = $clog2(HEIGHT),
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             rd_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_REQ-1:0]             rd_ready,
    output logic [NUM_REQ-1:0]             rd_rvalid,
    output logic [WIDTH-1:0]               rd_rdata,
    input  logic [NUM_REQ-1:0]             wr_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]  wr_data,
    output logic [NUM_REQ-1:0]             wr_ready,
    output logic                           mem_read_en,
    output logic [ADDR_W-1:0]              mem_read_addr,
    input  logic [WIDTH-1:0]               mem_qout,
    output logic                           mem_write_en,
    output logic [ADDR_W-1:0]              mem_write_addr,
    output logic [WIDTH-1:0]               mem_din
);

    logic [IW-1:0]      rd_gnt_id;
    logic [IW-1:0]      wr_gnt_id;
    logic               rd_gnt_any;
    logic               wr_gnt_any;
    logic [NUM_REQ-1:0] rd_rvalid_reg;
    logic [WIDTH-1:0]   rd_rdata_reg;

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_valid),
        .advance (rd_gnt_any),
        .gnt     (rd_ready),
        .gnt_id  (rd_gnt_id),
        .gnt_any (rd_gnt_any)
    );

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_valid),
        .advance (wr_gnt_any),
        .gnt     (wr_ready),
        .gnt_id  (wr_gnt_id),
        .gnt_any (wr_gnt_any)
    );

    // Idle buses are driven to zero to keep X out of the memory macro.
    assign mem_read_en    = rd_gnt_any;
    assign mem_read_addr  = rd_gnt_any ? rd_addr[rd_gnt_id] : '0;
    assign mem_write_en   = wr_gnt_any;
    assign mem_write_addr = wr_gnt_any ? wr_addr[wr_gnt_id] : '0;
    assign mem_din        = wr_gnt_any ? wr_data[wr_gnt_id] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rvalid_reg <= '0;
            rd_rdata_reg  <= '0;
        end else begin
            rd_rvalid_reg <= rd_ready;
            if (rd_gnt_any) begin
                rd_rdata_reg <= mem_qout;
            end
        end
    end

    // A return already in flight when reset rises is masked, not delivered.
    assign rd_rvalid = rd_rvalid_reg & {NUM_REQ{~rst}};
    assign rd_rdata  = rd_rdata_reg;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed and randomized checks of mem_rr_arbiter against hand-computed
// values and a small round-robin / memory reference model.
module tb_mem_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int H   = 128;
    localparam int AWB = 7;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         rd_valid;
    logic [N-1:0][AWB-1:0] rd_addr;
    logic [N-1:0]         rd_ready;
    logic [N-1:0]         rd_rvalid;
    logic [W-1:0]         rd_rdata;
    logic [N-1:0]         wr_valid;
    logic [N-1:0][AWB-1:0] wr_addr;
    logic [N-1:0][W-1:0]  wr_data;
    logic [N-1:0]         wr_ready;
    logic                 mem_read_en;
    logic [AWB-1:0]       mem_read_addr;
    logic [W-1:0]         mem_qout;
    logic                 mem_write_en;
    logic [AWB-1:0]       mem_write_addr;
    logic [W-1:0]         mem_din;

    logic [W-1:0] tb_mem [H];
    logic [W-1:0] shadow [H];

    int n_checks = 0;
    int n_errors = 0;

    mem_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .HEIGHT(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_valid       (rd_valid),
        .rd_addr        (rd_addr),
        .rd_ready       (rd_ready),
        .rd_rvalid      (rd_rvalid),
        .rd_rdata       (rd_rdata),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_qout       (mem_qout),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_din        (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory instance: 0-cycle read, clocked write.
    assign mem_qout = tb_mem[mem_read_addr];
    always @(posedge clk) begin
        if (mem_write_en) tb_mem[mem_write_addr] <= mem_din;
    end

    function automatic logic [W-1:0] memval(input int a);
        return W'(a * 257) ^ 16'h5A00;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rptr, wptr, rg, wg, prev_rv, prev_data;
        int rwait [N];
        int wwait [N];

        for (int i = 0; i < H; i++) tb_mem[i] = memval(i);
        rst = 1'b1;
        rd_valid = '0; wr_valid = '0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;

        // Reset: grants forced off even with requests pending
        rd_valid = 4'b1111; wr_valid = 4'b1111;
        #1;
        repeat (2) begin
            @(negedge clk);
            check("rst_rd_ready", 32'(rd_ready), 32'h0);
            check("rst_wr_ready", 32'(wr_ready), 32'h0);
            check("rst_rd_en", 32'(mem_read_en), 32'h0);
            check("rst_wr_en", 32'(mem_write_en), 32'h0);
            tick();
        end
        rst = 1'b0; rd_valid = '0; wr_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_rd_ready", 32'(rd_ready), 32'h0);
            check("idle_wr_ready", 32'(wr_ready), 32'h0);
            check("idle_en", 32'({mem_read_en, mem_write_en}), 32'h0);
            check("idle_rvalid", 32'(rd_rvalid), 32'h0);
            check("idle_rdata", 32'(rd_rdata), 32'h0);
            $display("idle cycle %0d", c);
            tick();
        end

        // All four requesters read continuously: grants 0,1,2,3,0,1,2,3
        rd_valid = 4'b1111;
        for (int i = 0; i < N; i++) rd_addr[i] = AWB'(10 + i);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_ready", 32'(rd_ready), 32'(1 << (k % 4)));
            check("rr_raddr", 32'(mem_read_addr), 32'(10 + k % 4));
            if (k > 0) begin
                check("rr_rvalid", 32'(rd_rvalid), 32'(1 << ((k - 1) % 4)));
                check("rr_rdata", 32'(rd_rdata), 32'(memval(10 + (k - 1) % 4)));
            end
            $display("read grant %0d -> rd_ready=%b", k, rd_ready);
            tick();
        end
        rd_valid = '0;
        @(negedge clk);
        check("rr_last_rvalid", 32'(rd_rvalid), 32'h8);
        check("rr_last_rdata", 32'(rd_rdata), 32'(memval(13)));
        check("rr_last_ready", 32'(rd_ready), 32'h0);
        tick();

        // Same-cycle read/write of addr 5 returns old data; next read sees new
        rd_valid = 4'b0010; rd_addr[1] = 7'd5;
        wr_valid = 4'b0100; wr_addr[2] = 7'd5; wr_data[2] = 16'hBEEF;
        @(negedge clk);
        check("rw_rd_ready", 32'(rd_ready), 32'h2);
        check("rw_wr_ready", 32'(wr_ready), 32'h4);
        check("rw_wr_en", 32'(mem_write_en), 32'h1);
        check("rw_waddr", 32'(mem_write_addr), 32'd5);
        check("rw_din", 32'(mem_din), 32'hBEEF);
        $display("read addr 5 req1 + write BEEF addr 5 req2");
        tick();
        wr_valid = '0;
        @(negedge clk);
        check("rw_old_rvalid", 32'(rd_rvalid), 32'h2);
        check("rw_old_rdata", 32'(rd_rdata), 32'(memval(5)));
        check("rw_again_ready", 32'(rd_ready), 32'h2);
        check("rw_again_wr_en", 32'(mem_write_en), 32'h0);
        $display("re-read addr 5 req1");
        tick();
        rd_valid = '0;
        @(negedge clk);
        check("rw_new_rdata", 32'(rd_rdata), 32'hBEEF);
        check("rw_new_rvalid", 32'(rd_rvalid), 32'h2);
        tick();

        // Requester 3 reads and writes, requester 0 reads (rd ptr=2, wr ptr=3)
        rd_valid = 4'b1001; rd_addr[3] = 7'd20; rd_addr[0] = 7'd22;
        wr_valid = 4'b1000; wr_addr[3] = 7'd21; wr_data[3] = 16'h1234;
        @(negedge clk);
        check("both_rd_ready", 32'(rd_ready), 32'h8);
        check("both_wr_ready", 32'(wr_ready), 32'h8);
        check("both_raddr", 32'(mem_read_addr), 32'd20);
        check("both_waddr", 32'(mem_write_addr), 32'd21);
        check("both_din", 32'(mem_din), 32'h1234);
        $display("req3 read+write, req0 waiting");
        tick();
        rd_valid = 4'b0001; wr_valid = '0;
        @(negedge clk);
        check("both_next_ready", 32'(rd_ready), 32'h1);
        check("both_rvalid3", 32'(rd_rvalid), 32'h8);
        check("both_rdata3", 32'(rd_rdata), 32'(memval(20)));
        $display("req0 read granted");
        tick();
        rd_valid = '0;
        @(negedge clk);
        check("both_rvalid0", 32'(rd_rvalid), 32'h1);
        check("both_rdata0", 32'(rd_rdata), 32'(memval(22)));
        tick();

        // Reset right after a read grant (rd ptr=1 -> grant 2)
        rd_valid = 4'b0100; rd_addr[2] = 7'd30;
        @(negedge clk);
        check("rstmid_grant", 32'(rd_ready), 32'h4);
        tick();
        rst = 1'b1;
        rd_valid = 4'b1111; wr_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            rd_addr[i] = AWB'(40 + i);
            wr_addr[i] = AWB'(50 + i);
            wr_data[i] = W'(16'hC000 + i);
        end
        @(negedge clk);
        check("rstmid_rvalid", 32'(rd_rvalid), 32'h0);
        check("rstmid_rd_ready", 32'(rd_ready), 32'h0);
        check("rstmid_wr_ready", 32'(wr_ready), 32'h0);
        check("rstmid_wr_en", 32'(mem_write_en), 32'h0);
        $display("reset asserted after read grant");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstpost_rd_ready", 32'(rd_ready), 32'h1);
        check("rstpost_wr_ready", 32'(wr_ready), 32'h1);
        check("rstpost_rvalid", 32'(rd_rvalid), 32'h0);
        check("rstpost_rdata", 32'(rd_rdata), 32'h0);
        $display("first grants after reset");
        tick();

        // Randomized phase against the reference model
        rst = 1'b1; rd_valid = '0; wr_valid = '0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < H; i++) shadow[i] = tb_mem[i];
        rptr = 0; wptr = 0; prev_rv = 0; prev_data = 0;
        for (int i = 0; i < N; i++) begin rwait[i] = 0; wwait[i] = 0; end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rd_valid[i] && $urandom_range(0, 99) < 60) begin
                    rd_valid[i] = 1'b1;
                    rd_addr[i]  = AWB'(64 + $urandom_range(0, 15));
                end
                if (!wr_valid[i] && $urandom_range(0, 99) < 50) begin
                    wr_valid[i] = 1'b1;
                    wr_addr[i]  = AWB'(64 + $urandom_range(0, 15));
                    wr_data[i]  = W'($urandom);
                end
            end
            @(negedge clk);
            rg = rr_pick(rd_valid, rptr);
            wg = rr_pick(wr_valid, wptr);
            check("rnd_rd_ready", 32'(rd_ready), (rg >= 0) ? 32'(1 << rg) : 32'h0);
            check("rnd_wr_ready", 32'(wr_ready), (wg >= 0) ? 32'(1 << wg) : 32'h0);
            check("rnd_rvalid", 32'(rd_rvalid), 32'(prev_rv));
            if (prev_rv != 0) check("rnd_rdata", 32'(rd_rdata), 32'(prev_data));
            if (rg >= 0) begin
                check("rnd_raddr", 32'(mem_read_addr), 32'(rd_addr[rg]));
                check("rnd_rwait", 32'(rwait[rg] <= N - 1), 32'h1);
                prev_data = int'(shadow[rd_addr[rg]]);
                prev_rv = 1 << rg;
                rptr = (rg + 1) % N;
            end else begin
                prev_rv = 0;
            end
            if (wg >= 0) begin
                check("rnd_waddr", 32'(mem_write_addr), 32'(wr_addr[wg]));
                check("rnd_din", 32'(mem_din), 32'(wr_data[wg]));
                check("rnd_wwait", 32'(wwait[wg] <= N - 1), 32'h1);
                shadow[wr_addr[wg]] = wr_data[wg];
                wptr = (wg + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                rwait[i] = (rd_valid[i] && i != rg) ? rwait[i] + 1 : 0;
                wwait[i] = (wr_valid[i] && i != wg) ? wwait[i] + 1 : 0;
            end
            tick();
            if (rg >= 0) rd_valid[rg] = 1'b0;
            if (wg >= 0) wr_valid[wg] = 1'b0;
        end
        $display("random phase complete: 10000 cycles");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
